// File: rtl/debug_trace_fifo.sv
// Trace capture FIFO: buffers {PC, instruction} samples from a core for a debug consumer.
// Optional macro TRACE_DEDUP_EN suppresses repeated PCs, such as a core stalled on one instruction.
module debug_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trace_en,
    input  logic                     clear,
    input  logic [31:0]              debug_pc,
    input  logic [31:0]              debug_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]      traceMem [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] dropCnt_q, dropCnt_d;

    logic             candidate;
    logic             full;
    logic             pop;
    logic             pushAccept;
    logic             pushDrop;
    logic [63:0]      headEntry;

`ifdef TRACE_DEDUP_EN
    // History covers both accepted and dropped candidates, so a stall while full is not counted repeatedly.
    logic [31:0] lastPc_q, lastPc_d;
    logic        lastPcValid_q, lastPcValid_d;

    assign candidate = trace_en && !(lastPcValid_q && (debug_pc == lastPc_q));

    always_comb begin
        lastPc_d      = lastPc_q;
        lastPcValid_d = lastPcValid_q;
        if (clear) begin
            lastPcValid_d = 1'b0;
        end else if (candidate) begin
            lastPc_d      = debug_pc;
            lastPcValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastPc_q      <= '0;
            lastPcValid_q <= 1'b0;
        end else begin
            lastPc_q      <= lastPc_d;
            lastPcValid_q <= lastPcValid_d;
        end
    end
`else
    assign candidate = trace_en;
`endif

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready && !clear;
    assign pushAccept = candidate && !clear && (!full || pop);
    assign pushDrop   = candidate && !clear && full && !pop;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dropCnt_d  = dropCnt_q;
        if (clear) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            dropCnt_d  = '0;
        end else begin
            if (pushAccept) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            if (pushAccept && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !pushAccept) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (pushDrop) begin
                overflow_d = 1'b1;
                if (dropCnt_q != '1) begin
                    dropCnt_d = dropCnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // Storage is deliberately unreset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            traceMem[wrPtr_q] <= {debug_pc, debug_instr};
        end
    end

    assign headEntry = traceMem[rdPtr_q];
    assign out_pc    = out_valid ? headEntry[63:32] : 32'h0;
    assign out_instr = out_valid ? headEntry[31:0]  : 32'h0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_debug_trace_fifo.sv
// Directed bench for debug_trace_fifo: table-driven ordering vectors plus hand-written
// sequences for fill/overflow, full push+pop, dedup, clear and asynchronous reset.
module tb_debug_trace_fifo;

    localparam logic [31:0] INSTR_KEY = 32'hA5A5_0F0F;

    logic        clk;
    logic        rst_n;
    logic        trace_en;
    logic        clear;
    logic [31:0] debug_pc;
    logic [31:0] debug_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks;
    int failures;

    typedef struct {
        logic        en;
        logic        clr;
        logic        rdy;
        logic [31:0] pc;
        int          expCount;
        logic        expValid;
        logic [31:0] expPc;
        logic        expOvf;
        int          expDrop;
    } vec_t;

    vec_t basicVecs[4];

    debug_trace_fifo #(.DEPTH(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trace_en   (trace_en),
        .clear      (clear),
        .debug_pc   (debug_pc),
        .debug_instr(debug_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, take the edge, and settle just past it.
    task automatic applyStimulus(input logic en, input logic clr, input logic rdy, input logic [31:0] pc);
        trace_en    = en;
        clear       = clr;
        out_ready   = rdy;
        debug_pc    = pc;
        debug_instr = pc ^ INSTR_KEY;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int expCount, input logic expValid,
                               input logic [31:0] expPc, input logic expOvf, input int expDrop);
        logic [31:0] expInstr;
        expInstr = expValid ? (expPc ^ INSTR_KEY) : 32'h0;
        checks++;
        if (int'(count) != expCount) begin
            failures++;
            $display("[TB] FAIL %s count: got %0d expected %0d", tag, count, expCount);
        end
        checks++;
        if (out_valid !== expValid) begin
            failures++;
            $display("[TB] FAIL %s out_valid: got %b expected %b", tag, out_valid, expValid);
        end
        checks++;
        if (out_pc !== (expValid ? expPc : 32'h0)) begin
            failures++;
            $display("[TB] FAIL %s out_pc: got %h expected %h", tag, out_pc, expValid ? expPc : 32'h0);
        end
        checks++;
        if (out_instr !== expInstr) begin
            failures++;
            $display("[TB] FAIL %s out_instr: got %h expected %h", tag, out_instr, expInstr);
        end
        checks++;
        if (overflow !== expOvf) begin
            failures++;
            $display("[TB] FAIL %s overflow: got %b expected %b", tag, overflow, expOvf);
        end
        checks++;
        if (int'(drop_cnt) != expDrop) begin
            failures++;
            $display("[TB] FAIL %s drop_cnt: got %0d expected %0d", tag, drop_cnt, expDrop);
        end
    endtask

    initial begin
        int dedupCounts[4];
        logic [31:0] dedupPcs[4];
        int secondCount;
        logic [31:0] secondPc;

        checks   = 0;
        failures = 0;

        // Ordering with a consumer always ready: each sample appears one cycle after capture.
        basicVecs[0] = '{en:1'b1, clr:1'b0, rdy:1'b1, pc:32'h0, expCount:1, expValid:1'b1, expPc:32'h0, expOvf:1'b0, expDrop:0};
        basicVecs[1] = '{en:1'b1, clr:1'b0, rdy:1'b1, pc:32'h4, expCount:1, expValid:1'b1, expPc:32'h4, expOvf:1'b0, expDrop:0};
        basicVecs[2] = '{en:1'b1, clr:1'b0, rdy:1'b1, pc:32'h8, expCount:1, expValid:1'b1, expPc:32'h8, expOvf:1'b0, expDrop:0};
        basicVecs[3] = '{en:1'b0, clr:1'b0, rdy:1'b1, pc:32'h0, expCount:0, expValid:1'b0, expPc:32'h0, expOvf:1'b0, expDrop:0};

`ifdef TRACE_DEDUP_EN
        dedupCounts = '{1, 1, 1, 2};
        secondCount = 1;
        secondPc    = 32'h14;
`else
        dedupCounts = '{1, 2, 3, 4};
        secondCount = 3;
        secondPc    = 32'h10;
`endif
        dedupPcs = '{32'h10, 32'h10, 32'h10, 32'h14};

        rst_n       = 1'b0;
        trace_en    = 1'b0;
        clear       = 1'b0;
        out_ready   = 1'b0;
        debug_pc    = 32'h0;
        debug_instr = 32'h0;
        #3;
        checkOutput("reset", 0, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(basicVecs[i].en, basicVecs[i].clr, basicVecs[i].rdy, basicVecs[i].pc);
            checkOutput($sformatf("basic[%0d]", i), basicVecs[i].expCount, basicVecs[i].expValid,
                        basicVecs[i].expPc, basicVecs[i].expOvf, basicVecs[i].expDrop);
        end

        $display("[TB] fill and overflow");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(4 * i));
            checkOutput($sformatf("fill[%0d]", i), (i < 16) ? i + 1 : 16, 1'b1, 32'h1000,
                        (i >= 16), (i >= 16) ? i - 15 : 0);
        end

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
        checkOutput("full_push_pop", 16, 1'b1, 32'h1004, 1'b1, 4);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
            checkOutput($sformatf("drain[%0d]", i), 15 - i, (i < 15),
                        (i < 14) ? 32'h1008 + 32'(4 * i) : 32'h100, 1'b1, 4);
        end

        $display("[TB] dedup");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("dedup_clear", 0, 1'b0, 32'h0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, dedupPcs[i]);
            checkOutput($sformatf("dedup[%0d]", i), dedupCounts[i], 1'b1, 32'h10, 1'b0, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("dedup_second", secondCount, 1'b1, secondPc, 1'b0, 0);

        $display("[TB] clear with pending push");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h3000 + 32'(4 * i));
        end
        checkOutput("clear_fill", 16, 1'b1, 32'h3000, 1'b1, 1);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        end
        checkOutput("clear_pre", 5, 1'b1, 32'h302C, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h2000);
        checkOutput("clear_edge", 0, 1'b0, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("clear_after", 0, 1'b0, 32'h0, 1'b0, 0);

        $display("[TB] asynchronous reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h4000 + 32'(4 * i));
        end
        checkOutput("areset_pre", 3, 1'b1, 32'h4000, 1'b0, 0);
        trace_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_mid", 0, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h5000);
        checkOutput("areset_resume", 1, 1'b1, 32'h5000, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_trace_fifo.md
DEBUG_TRACE_FIFO -- requirements
Module: debug_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of trace entries; a power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 16, width of the dropped-sample counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port trace_en  input  1  capture enable.
REQ-006 SHALL have port clear  input  1  synchronous flush of all entries and status.
REQ-007 SHALL have port debug_pc  input  32  core's current PC.
REQ-008 SHALL have port debug_instr  input  32  core's current instruction.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-011 SHALL have port out_pc  output  32  PC of the head entry.
REQ-012 SHALL have port out_instr  output  32  instruction of the head entry.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 SHALL have port overflow  output  1  sticky flag: a sample was dropped.
REQ-015 SHALL have port drop_cnt  output  CNT_W  count of dropped samples, saturating.

Function
REQ-016 SHALL form a push candidate on every clk edge where trace_en=1, carrying {debug_pc, debug_instr} sampled at that edge.
REQ-017 SHALL define pop as out_valid=1 and out_ready=1 at the same edge; it removes the head entry.
REQ-018 SHALL drive out_valid=1 exactly when count>0.
REQ-019 SHALL present the head entry on out_pc/out_instr while out_valid=1, and 0 on both while out_valid=0.
REQ-020 SHALL hold out_pc/out_instr stable while out_valid=1 and out_ready=0.
REQ-021 SHALL make a sample pushed at edge N visible at the head no earlier than the cycle after edge N (1-cycle minimum latency); entries emerge in FIFO order.
REQ-022 SHALL accept a push when count<DEPTH, or when count==DEPTH and a pop occurs at the same edge (count unchanged).
REQ-023 SHALL, when a push is rejected (full with no pop), discard the sample, set overflow=1, and increment drop_cnt, saturating at all-ones.
REQ-024 SHALL, on a simultaneous push and pop with 0<count<DEPTH, leave count unchanged.
REQ-025 SHALL, with count==0, accept a push and ignore out_ready.
REQ-026 SHALL wrap the read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-027 SHALL, when clear=1 at an edge, set count=0, overflow=0 and drop_cnt=0, and empty the dedup history.
REQ-028 SHALL give clear priority over any push or pop at the same edge; no sample is captured and no pop occurs.

Reset
REQ-029 SHALL, while rst_n=0, immediately force count=0, out_valid=0, out_pc=0, out_instr=0, overflow=0, drop_cnt=0, pointers=0, and empty the dedup history, independent of clk.
REQ-030 SHALL, when reset is asserted mid-operation, discard all stored entries; after release, operation resumes empty at the first clk edge with rst_n=1.
REQ-031 SHALL leave storage array contents unreset; they are unobservable because out_pc/out_instr are masked when empty.

Configuration
REQ-032 SHALL use macro TRACE_DEDUP_EN to enable stall deduplication.
REQ-033 SHALL, with TRACE_DEDUP_EN defined, suppress a push candidate whose debug_pc equals the PC of the last accepted-or-dropped candidate since reset/clear. Suppressed candidates are neither pushed nor counted as dropped. The first candidate after reset/clear is never suppressed.
REQ-034 SHALL, with TRACE_DEDUP_EN undefined, treat every trace_en=1 edge as a push candidate; no PC history register is implemented.

Verification
REQ-035 SHALL cover basic order: trace_en=1, out_ready=1, PCs 0x0,0x4,0x8 on 3 edges -> out_pc sequence 0x0,0x4,0x8 each 1 cycle later; count never exceeds 1.
REQ-036 SHALL cover fill and overflow: DEPTH=16, out_ready=0, 20 distinct PCs -> count=16, overflow=1, drop_cnt=4; draining yields the first 16 PCs in order.
REQ-037 SHALL cover full with simultaneous push and pop: count=16, out_ready=1, new PC 0x100 -> count stays 16, overflow unchanged, 0x100 eventually read last.
REQ-038 SHALL cover dedup: with TRACE_DEDUP_EN, PCs 0x10,0x10,0x10,0x14 -> 2 entries (0x10, 0x14); without the macro -> 4 entries.
REQ-039 SHALL cover clear: clear=1 with count=5, overflow=1 and a push pending -> next cycle count=0, out_valid=0, overflow=0, drop_cnt=0.
REQ-040 SHALL cover async reset: rst_n=0 asserted between edges with count=3 -> out_valid=0 and count=0 before the next clk edge.
